uart_hex_tx: RTL and testbench

- Formatter stage directly upstream of the uart block's transmit path.
- Accepts one DATA_WIDTH-bit word and emits its ASCII hex representation, optionally "0x"-prefixed and CR/LF-terminated, as a byte stream into the UART TX FIFO through wr_uart/w_data, honouring tx_full.
- Used for debug/telemetry printing of register values over the serial line.

---
 rtl/uart_fmt_pkg.sv | 29 ++
 rtl/uart_hex_tx.sv | 107 ++++++++++
 tb/tb_uart_hex_tx.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_fmt_pkg.sv
// Shared definitions for the hex formatter: ASCII codes, FSM states and
// the nibble-to-ASCII conversion.
package uart_fmt_pkg;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_X  = 8'h78;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PFX0,
        S_PFX1,
        S_DIGIT,
        S_CR,
        S_LF,
        S_DONE
    } state_t;

    // Uppercase hex digits: 0-9 map onto '0'.., 10-15 onto 'A'..
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return CH_0 + {4'h0, nib};
        end
        return CH_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_hex_tx.sv
// Prints one captured word as ASCII hex ("0x" prefix and CR/LF optional)
// into the UART TX FIFO, stalling whenever the FIFO reports full.
module uart_hex_tx
    import uart_fmt_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int SEND_PREFIX  = 1,
    parameter int SEND_NEWLINE = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  ready,
    output logic                  done_tick,
    input  logic                  tx_full,
    output logic                  wr_uart,
    output logic [7:0]            w_data
);

    localparam int NDIG = DATA_WIDTH / 4;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            nib;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Select the nibble addressed by the digit counter (MSB nibble first).
    always_comb begin
        nib = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CW'(i)) begin
                nib = data_q[4*i +: 4];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        done_tick = 1'b0;
        wr_uart   = 1'b0;
        w_data    = 8'h00;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    data_d  = din;
                    cnt_d   = CW'(NDIG - 1);
                    state_d = (SEND_PREFIX != 0) ? S_PFX0 : S_DIGIT;
                end
            end
            S_PFX0: begin
                w_data  = CH_0;
                wr_uart = ~tx_full;
                if (!tx_full) state_d = S_PFX1;
            end
            S_PFX1: begin
                w_data  = CH_X;
                wr_uart = ~tx_full;
                if (!tx_full) state_d = S_DIGIT;
            end
            S_DIGIT: begin
                w_data  = nib2ascii(nib);
                wr_uart = ~tx_full;
                if (!tx_full) begin
                    if (cnt_q == '0) begin
                        state_d = (SEND_NEWLINE != 0) ? S_CR : S_DONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_CR: begin
                w_data  = CH_CR;
                wr_uart = ~tx_full;
                if (!tx_full) state_d = S_LF;
            end
            S_LF: begin
                w_data  = CH_LF;
                wr_uart = ~tx_full;
                if (!tx_full) state_d = S_DONE;
            end
            S_DONE: begin
                done_tick = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx: table-driven and randomized words with FIFO-full
// stalls, ignored starts, mid-word reset and an 8-bit no-frills instance.
module tb_uart_hex_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [31:0] din;
    logic        ready;
    logic        done_tick;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;

    logic        start8;
    logic [7:0]  din8;
    logic        ready8;
    logic        done8;
    logic        tx_full8;
    logic        wr8;
    logic [7:0]  wdata8;

    uart_hex_tx u_dut (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .ready(ready), .done_tick(done_tick), .tx_full(tx_full),
        .wr_uart(wr_uart), .w_data(w_data)
    );

    uart_hex_tx #(.DATA_WIDTH(8), .SEND_PREFIX(0), .SEND_NEWLINE(0)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .din(din8),
        .ready(ready8), .done_tick(done8), .tx_full(tx_full8),
        .wr_uart(wr8), .w_data(wdata8)
    );

    typedef struct {
        logic [31:0] din;
        logic [63:0] stall;
        int          ign_cyc;
        int          exp_done;
        bit          use_exp;
        logic [95:0] exp_bytes;
    } vec_t;

    int         nvec = 0;
    int         nmis = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the printed text of a 32-bit word, built digit by digit.
    task automatic model_bytes(input logic [31:0] w);
        int d;
        exp_q.delete();
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
        for (int k = 7; k >= 0; k--) begin
            d = int'((w >> (4 * k)) & 32'hF);
            if (d < 10) exp_q.push_back(8'(48 + d));
            else        exp_q.push_back(8'(65 + d - 10));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic run_word(input vec_t v);
        int c;
        int sent;
        int exp_done;
        int done_cyc;
        int ready_cyc;
        logic [7:0] b;
        if (v.use_exp) begin
            exp_q.delete();
            for (int i = 0; i < 12; i++) begin
                b = v.exp_bytes[95 - 8*i -: 8];
                exp_q.push_back(b);
            end
        end else begin
            model_bytes(v.din);
        end
        if (v.exp_done > 0) begin
            exp_done = v.exp_done;
        end else begin
            c = 1;
            sent = 0;
            while (sent < exp_q.size()) begin
                if (c >= 64 || !v.stall[c]) sent++;
                c++;
            end
            exp_done = c;
        end
        start   = 1'b1;
        din     = v.din;
        tx_full = 1'b0;
        @(posedge clk);
        #1;
        din       = $urandom;
        done_cyc  = -1;
        ready_cyc = -1;
        for (int cyc = 1; cyc < 200; cyc++) begin
            tx_full = (cyc < 64) ? v.stall[cyc] : 1'b0;
            start   = (cyc == v.ign_cyc);
            if (start) din = 32'h12345678;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                check("wr_vs_full", {31'd0, wr_uart}, {31'd0, ~tx_full});
                if (wr_uart) check("byte", {24'd0, w_data}, {24'd0, exp_q.pop_front()});
                else         check("hold", {24'd0, w_data}, {24'd0, exp_q[0]});
            end else if (wr_uart) begin
                check("extra_write", {31'd0, wr_uart}, 32'd0);
            end
            if (done_tick) begin
                if (done_cyc >= 0) check("double_done", 32'(cyc), 32'(done_cyc));
                done_cyc = cyc;
            end
            if (ready) begin
                ready_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        start   = 1'b0;
        tx_full = 1'b0;
        check("done_cycle", 32'(done_cyc), 32'(exp_done));
        check("ready_cycle", 32'(ready_cyc), 32'(exp_done + 1));
        check("bytes_left", 32'(exp_q.size()), 32'd0);
    endtask

    localparam logic [95:0] BEEF = 96'h3078_4445_4144_4245_4546_0D0A;
    localparam logic [95:0] F_WD = 96'h3078_3030_3030_3030_3046_0D0A;

    vec_t tbl[3];
    vec_t v;
    int   dcount;

    initial begin
        tbl[0] = '{din: 32'hDEADBEEF, stall: 64'h0,  ign_cyc: -1, exp_done: 13, use_exp: 1, exp_bytes: BEEF};
        tbl[1] = '{din: 32'hDEADBEEF, stall: 64'hF8, ign_cyc: -1, exp_done: 18, use_exp: 1, exp_bytes: BEEF};
        tbl[2] = '{din: 32'hDEADBEEF, stall: 64'h0,  ign_cyc: 4,  exp_done: 13, use_exp: 1, exp_bytes: BEEF};

        reset = 1'b0; start = 1'b0; din = '0; tx_full = 1'b0;
        start8 = 1'b0; din8 = '0; tx_full8 = 1'b0;
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_wr", {31'd0, wr_uart}, 32'd0);
        check("rst_done", {31'd0, done_tick}, 32'd0);
        check("rst_wdata", {24'd0, w_data}, 32'd0);
        check("rst_ready8", {31'd0, ready8}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Back-to-back: each run starts in the cycle ready of the previous returned.
        for (int i = 0; i < 3; i++) run_word(tbl[i]);

        for (int i = 0; i < 8; i++) begin
            v.din       = $urandom;
            v.stall     = {$urandom, $urandom} & {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FFFE;
            v.ign_cyc   = (i % 2 == 0) ? int'($urandom_range(1, 12)) : -1;
            v.exp_done  = 0;
            v.use_exp   = 0;
            v.exp_bytes = '0;
            run_word(v);
        end

        // Reset during the third digit (cycle 5) aborts without done_tick.
        start = 1'b1;
        din   = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort_wr", {31'd0, wr_uart}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_wdata", {24'd0, w_data}, 32'd0);
        dcount = 0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_tick) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        check("abort_idle", {31'd0, ready}, 32'd1);
        v = '{din: 32'h0000000F, stall: 64'h0, ign_cyc: -1, exp_done: 13, use_exp: 1, exp_bytes: F_WD};
        run_word(v);

        // Narrow instance: 0xA5 prints as "A5" with no prefix or newline.
        @(posedge clk);
        #1;
        start8 = 1'b1;
        din8   = 8'hA5;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        din8   = 8'h00;
        @(negedge clk);
        check("w8_c1", {22'd0, wr8, wdata8, done8, ready8}, {22'd0, 1'b1, 8'h41, 1'b0, 1'b0});
        @(negedge clk);
        check("w8_c2", {22'd0, wr8, wdata8, done8, ready8}, {22'd0, 1'b1, 8'h35, 1'b0, 1'b0});
        @(negedge clk);
        check("w8_c3", {22'd0, wr8, wdata8, done8, ready8}, {22'd0, 1'b0, 8'h00, 1'b1, 1'b0});
        @(negedge clk);
        check("w8_c4", {22'd0, wr8, wdata8, done8, ready8}, {22'd0, 1'b0, 8'h00, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
